// File: rtl/seven_seg_mux_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_mux_driver
//
// Time-multiplexed driver for an N-digit common-anode seven-segment bank.
// A double-buffered frame of hex nibbles (with per-digit enable and decimal
// point) is scanned one digit per refresh slot. New frames are staged in a
// shadow buffer and promoted to the active buffer only at a frame boundary,
// so a frame that is already being scanned never shows a mix of old and new
// data.
//
// Parameters:
//   NUM_DIGITS  - digits scanned (1..16)
//   REFRESH_DIV - clock cycles per digit slot (>= 2)
//   ACTIVE_LOW  - 1: seg, dp_out and an are inverted at the pins
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   value      in   hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   digit_en   in   per-digit enable, 0 blanks the digit
//   dp         in   per-digit decimal point request
//   load       in   strobe capturing value/digit_en/dp into the shadow buffer
//   seg        out  segments {A,B,C,D,E,F,G}, registered
//   dp_out     out  decimal point segment, registered
//   an         out  one-hot digit select, registered
//   scan_idx   out  index of the digit currently being scanned
//   frame_done out  one-cycle pulse at the end of each full scan, registered
//
// Optional feature macro: SEVEN_SEG_LZB_EN
//   When defined, leading zeros (from the top digit down, never digit 0) are
//   blanked in addition to digit_en blanking.
// -----------------------------------------------------------------------------
module seven_seg_mux_driver #(
  parameter int  NUM_DIGITS  = 8,
  parameter int  REFRESH_DIV = 100000,
  parameter bit  ACTIVE_LOW  = 1'b1,
  localparam int SCAN_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SCAN_W-1:0]       scan_idx,
  output logic                    frame_done
);

  localparam int                    CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(NUM_DIGITS - 1);

  // XOR masks applied after all logic; they also give the "off" pin levels.
  localparam logic [6:0]            SEG_POL   = {7{ACTIVE_LOW}};
  localparam logic                  DP_POL    = ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_POL    = {NUM_DIGITS{ACTIVE_LOW}};

  // Scan timing
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SCAN_W-1:0]       scan_q, scan_d;
  logic                    tick;
  logic                    frame_end;

  // Frame buffers
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0]   shd_en_q, shd_en_d;
  logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;

  // Digit selection
  logic [NUM_DIGITS-1:0]   vis;
  logic [3:0]              cur_nib;
  logic                    cur_vis;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   an_raw;

  // Output registers (already in pin polarity)
  logic [6:0]              seg_q, seg_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b0001101;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      4'hF: g = 7'b1000111;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------------------
  // Prescaler and scan index
  // ---------------------------------------------------------------------------
  assign tick      = (cnt_q == CNT_LAST);
  assign frame_end = tick && (scan_q == SCAN_LAST);

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default on entry, so
    // no path leaves it unassigned and no latch is inferred.
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    scan_d = scan_q;
    if (tick) begin
      scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffer: shadow collects loads, active is swapped only at the frame
  // boundary. A load on the boundary cycle itself goes straight to active.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    shd_val_d = shd_val_q;
    shd_en_d  = shd_en_q;
    shd_dp_d  = shd_dp_q;
    act_val_d = act_val_q;
    act_en_d  = act_en_q;
    act_dp_d  = act_dp_q;

    if (load) begin
      shd_val_d = value;
      shd_en_d  = digit_en;
      shd_dp_d  = dp;
    end

    if (frame_end) begin
      if (load) begin
        act_val_d = value;
        act_en_d  = digit_en;
        act_dp_d  = dp;
      end else if (pending_q) begin
        act_val_d = shd_val_q;
        act_en_d  = shd_en_q;
        act_dp_d  = shd_dp_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Visibility mask: digit_en, optionally combined with leading-zero blanking.
  // ---------------------------------------------------------------------------
`ifdef SEVEN_SEG_LZB_EN
  always_comb begin
    logic                  leading;
    logic [NUM_DIGITS-1:0] lzb_keep;
    leading  = 1'b1;
    lzb_keep = '1;
    // Walk down from the most significant digit; digit 0 always stays lit.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (leading && (act_val_q[4*i +: 4] == 4'h0)) begin
        lzb_keep[i] = 1'b0;
      end else begin
        leading = 1'b0;
      end
    end
    vis = act_en_q & lzb_keep;
  end
`else
  assign vis = act_en_q;
`endif

  // ---------------------------------------------------------------------------
  // Current digit mux and output next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_nib = 4'h0;
    cur_vis = 1'b0;
    cur_dp  = 1'b0;
    an_raw  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == SCAN_W'(i)) begin
        cur_nib = act_val_q[4*i +: 4];
        cur_vis = vis[i];
        cur_dp  = act_dp_q[i];
        // Dead time on the first cycle of each slot suppresses ghosting.
        an_raw[i] = vis[i] && (cnt_q != '0);
      end
    end
  end

  assign seg_d        = (cur_vis ? hex_glyph(cur_nib) : 7'b0000000) ^ SEG_POL;
  assign dp_out_d     = (cur_vis & cur_dp) ^ DP_POL;
  assign an_d         = an_raw ^ AN_POL;
  assign frame_done_d = frame_end;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      cnt_q        <= '0;
      scan_q       <= '0;
      pending_q    <= 1'b0;
      // NOTE: the frame buffers are reset too: the display must come up blank,
      // not showing whatever the flops powered up with.
      shd_val_q    <= '0;
      shd_en_q     <= '0;
      shd_dp_q     <= '0;
      act_val_q    <= '0;
      act_en_q     <= '0;
      act_dp_q     <= '0;
      seg_q        <= SEG_POL;
      dp_out_q     <= DP_POL;
      an_q         <= AN_POL;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      scan_q       <= scan_d;
      pending_q    <= pending_d;
      shd_val_q    <= shd_val_d;
      shd_en_q     <= shd_en_d;
      shd_dp_q     <= shd_dp_d;
      act_val_q    <= act_val_d;
      act_en_q     <= act_en_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      dp_out_q     <= dp_out_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp_out     = dp_out_q;
  assign an         = an_q;
  assign scan_idx   = scan_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_mux_driver
//
// Bench for seven_seg_mux_driver with NUM_DIGITS=4, REFRESH_DIV=4,
// ACTIVE_LOW=1. Whenever a frame's content becomes known (after reset or a
// load), the expected pin values for every cycle of that frame are pushed to
// a scoreboard queue tagged with the cycle they must appear on; a monitor on
// the falling edge pops and compares them.
//
// Timing model: cyc counts rising edges since reset was released. At the
// falling edge with cyc = m the registered outputs reflect internal state
// e = m-1, where prescaler = e % 4, slot = (e / 4) % 4, frame = e / 16, and
// scan_idx shows state m.
// -----------------------------------------------------------------------------
module tb_seven_seg_mux_driver;

  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam int FRAME_CYC = ND * DIV;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   value;
  logic [3:0]    digit_en;
  logic [3:0]    dp;
  logic          load;
  logic [6:0]    seg;
  logic          dp_out;
  logic [3:0]    an;
  logic [1:0]    scan_idx;
  logic          frame_done;

  seven_seg_mux_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (DIV),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .digit_en   (digit_en),
    .dp         (dp),
    .load       (load),
    .seg        (seg),
    .dp_out     (dp_out),
    .an         (an),
    .scan_idx   (scan_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic [1:0] scan;
  } rec_t;

  rec_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b0001101;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [3:0] lzb_mask(input logic [15:0] v);
    logic [3:0] m;
    m = 4'b1111;
`ifdef SEVEN_SEG_LZB_EN
    for (int i = 3; i >= 1; i--) begin
      if (v[4*i +: 4] != 4'h0) break;
      m[i] = 1'b0;
    end
`endif
    return m;
  endfunction

  // Expected active-low pin values at falling edge cyc = m for a frame
  // holding (v, en, d).
  function automatic rec_t expect_at(input int m, input logic [15:0] v,
                                     input logic [3:0] en, input logic [3:0] d);
    rec_t       r;
    int         e, cnt, slot;
    logic [3:0] show;
    e    = m - 1;
    cnt  = e % DIV;
    slot = (e / DIV) % ND;
    show = en & lzb_mask(v);
    r.cyc  = m;
    r.an   = 4'b1111;
    if (cnt != 0 && show[slot]) r.an[slot] = 1'b0;
    r.seg  = show[slot] ? ~glyph(v[4*slot +: 4]) : 7'b1111111;
    r.dp   = ~(show[slot] & d[slot]);
    r.fd   = (cnt == DIV - 1) && (slot == ND - 1);
    r.scan = 2'((m / DIV) % ND);
    return r;
  endfunction

  // Push expectations for the first n cycles of frame f.
  task automatic push_frame(input int f, input logic [15:0] v, input logic [3:0] en,
                            input logic [3:0] d, input int n);
    for (int k = 1; k <= n; k++) sb_q.push_back(expect_at(f * FRAME_CYC + k, v, en, d));
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (!reset && sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      r = sb_q.pop_front();
      check($sformatf("cycle@%0d", r.cyc), cyc, r.cyc);
      check($sformatf("an@%0d", r.cyc), an, r.an);
      check($sformatf("seg@%0d", r.cyc), seg, r.seg);
      check($sformatf("dp_out@%0d", r.cyc), dp_out, r.dp);
      check($sformatf("frame_done@%0d", r.cyc), frame_done, r.fd);
      check($sformatf("scan_idx@%0d", r.cyc), scan_idx, r.scan);
    end
  end

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 200 && cyc != target; i++) @(negedge clk);
    check($sformatf("reach_cycle_%0d", target), cyc, target);
  endtask

  // Present a one-cycle load while the DUT is in state e.
  task automatic load_at(input int e, input logic [15:0] v, input logic [3:0] en,
                         input logic [3:0] d);
    wait_cyc(e);
    value    = v;
    digit_en = en;
    dp       = d;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_an"}, an, 4'b1111);
    check({tag, "_seg"}, seg, 7'b1111111);
    check({tag, "_dp_out"}, dp_out, 1'b1);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_scan_idx"}, scan_idx, 2'd0);
  endtask

  initial begin
    reset    = 1'b1;
    value    = '0;
    digit_en = '0;
    dp       = '0;
    load     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;

    // Frame 0: reset contents, everything blank.
    push_frame(0, 16'h0000, 4'b0000, 4'b0000, FRAME_CYC);

    // Mid-frame load, shown from frame 1.
    load_at(2, 16'h12AF, 4'b1111, 4'b0001);
    push_frame(1, 16'h12AF, 4'b1111, 4'b0001, FRAME_CYC);

    // Two loads during frame 1 while it is being scanned: no tearing of
    // slots 1..3, and the second load wins in frame 2.
    load_at(21, 16'h5555, 4'b1111, 4'b1111);
    load_at(25, 16'h0000, 4'b1111, 4'b0000);
    push_frame(2, 16'h0000, 4'b1111, 4'b0000, FRAME_CYC);

    // Load on the boundary cycle: visible from slot 0 of frame 3, and it
    // must persist into frame 4 (nothing left pending).
    load_at(47, 16'h8888, 4'b0101, 4'b1110);
    push_frame(3, 16'h8888, 4'b0101, 4'b1110, FRAME_CYC);
    push_frame(4, 16'h8888, 4'b0101, 4'b1110, FRAME_CYC);

    // Leading-zero pattern, then reset in the middle of frame 5.
    load_at(66, 16'h0030, 4'b1111, 4'b0000);
    push_frame(5, 16'h0030, 4'b1111, 4'b0000, 8);

    wait_cyc(90);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    @(negedge clk);
    check_reset_state("midrst_hold");
    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
